// File: rtl/spike_event_scheduler_if.sv
// Handshake bundle between the four direction request channels, the event
// queue head consumer and the stall interrupt logic of spike_event_scheduler.
interface spike_event_scheduler_if #(
  parameter int WEIGHT_W   = 16,
  parameter int FIFO_DEPTH = 8
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic                  enable;
  logic [3:0]            req_valid;
  logic [4*WEIGHT_W-1:0] req_weight;
  logic [3:0]            req_ready;
  logic                  out_valid;
  logic [1:0]            out_dir;
  logic [WEIGHT_W-1:0]   out_weight;
  logic                  out_ready;
  logic [CW-1:0]         fifo_count;
  logic                  stall_irq;
  logic                  irq_clear;

  modport master (
    output enable, req_valid, req_weight, out_ready, irq_clear,
    input  req_ready, out_valid, out_dir, out_weight, fifo_count, stall_irq
  );

  modport slave (
    input  enable, req_valid, req_weight, out_ready, irq_clear,
    output req_ready, out_valid, out_dir, out_weight, fifo_count, stall_irq
  );
endinterface

// File: rtl/spike_event_scheduler.sv
// Round-robin arbiter over four direction channels feeding a FWFT event queue,
// with a sticky starvation interrupt. Define SPIKE_COALESCE_EN to merge same-direction tail events.
module spike_event_scheduler #(
  parameter int WEIGHT_W    = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int STALL_LIMIT = 64
) (
  input logic                   clk,
  input logic                   rst,
  spike_event_scheduler_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STALL_LIMIT + 1);

  typedef struct packed {
    logic [1:0]          dir;
    logic [WEIGHT_W-1:0] weight;
  } evt_t;

  evt_t               mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr, tail_ptr;
  logic [CW-1:0]      count;
  logic [1:0]         rr_ptr;
  logic [SW-1:0]      stall_cnt;
  logic               irq;

  logic               win_found, full, pop, push, grant, merge, accept;
  logic [1:0]         win;
  logic [WEIGHT_W-1:0] win_weight, merged_weight;
  logic [WEIGHT_W:0]  sum;

  // Lowest rotated offset from rr_ptr wins; scan high-to-low so it is written last.
  always_comb begin
    logic [1:0] idx;
    idx       = '0;
    win_found = 1'b0;
    win       = rr_ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = rr_ptr + 2'(i);
      if (bus.req_valid[idx]) begin
        win_found = 1'b1;
        win       = idx;
      end
    end
  end

  assign win_weight = bus.req_weight[win*WEIGHT_W +: WEIGHT_W];
  assign full       = (count == CW'(FIFO_DEPTH));
  assign pop        = bus.out_valid && bus.out_ready;
  assign tail_ptr   = wr_ptr - AW'(1);
  assign sum        = {1'b0, mem[tail_ptr].weight} + {1'b0, win_weight};
  assign merged_weight = sum[WEIGHT_W] ? {WEIGHT_W{1'b1}} : sum[WEIGHT_W-1:0];

`ifdef SPIKE_COALESCE_EN
  // A lone entry that is leaving this cycle must not absorb the new event.
  assign merge  = win_found && (count != '0) && (mem[tail_ptr].dir == win) &&
                  ((count >= CW'(2)) || !pop);
  assign accept = !full || merge;
`else
  assign merge  = 1'b0;
  assign accept = !full;
`endif

  assign grant         = bus.enable && !rst && win_found && accept;
  assign push          = grant && !merge;
  assign bus.req_ready = grant ? (4'b0001 << win) : 4'b0000;

  assign bus.out_valid  = (count != '0);
  assign bus.out_dir    = bus.out_valid ? mem[rd_ptr].dir    : 2'b00;
  assign bus.out_weight = bus.out_valid ? mem[rd_ptr].weight : '0;
  assign bus.fifo_count = count;
  assign bus.stall_irq  = irq;

  // Storage needs no reset; occupancy and output gating hide stale entries.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= '{dir: win, weight: win_weight};
    else if (grant && merge)
      mem[tail_ptr].weight <= merged_weight;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      rr_ptr    <= 2'd0;
      stall_cnt <= '0;
      irq       <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (grant) rr_ptr <= win + 2'd1;

      if (|bus.req_valid && full)
        stall_cnt <= (stall_cnt == SW'(STALL_LIMIT)) ? stall_cnt : stall_cnt + SW'(1);
      else
        stall_cnt <= '0;

      if (stall_cnt == SW'(STALL_LIMIT)) irq <= 1'b1;
      else if (bus.irq_clear)            irq <= 1'b0;
    end
  end
endmodule

// File: tb/tb_spike_event_scheduler.sv
// Directed bench for spike_event_scheduler: grant order, queue contents via a
// scoreboard, full/stall/interrupt behaviour, reset flush and coalescing.
module tb_spike_event_scheduler;
  localparam int W = 16;
  localparam int D = 8;

  logic clk = 1'b0;
  logic rst;
  logic [W-1:0] wt [4];
  logic [W+1:0] sb [$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spike_event_scheduler_if #(.WEIGHT_W(W), .FIFO_DEPTH(D)) bus ();

  spike_event_scheduler #(.WEIGHT_W(W), .FIFO_DEPTH(D), .STALL_LIMIT(64)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign bus.req_weight = {wt[3], wt[2], wt[1], wt[0]};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: check combinational/head state, score pops, record expected pushes.
  task automatic cyc(input logic [3:0] exp_rdy);
    logic [W+1:0] e;
    #1;
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    chk("fifo_count", 32'(bus.fifo_count), sb.size());
    chk("out_valid", 32'(bus.out_valid), 32'(sb.size() != 0));
    if (bus.out_valid && bus.out_ready && sb.size() != 0) begin
      e = sb.pop_front();
      chk("out_dir", 32'(bus.out_dir), 32'(e[W+1:W]));
      chk("out_weight", 32'(bus.out_weight), 32'(e[W-1:0]));
    end
    for (int k = 0; k < 4; k++)
      if (exp_rdy[k]) sb.push_back({2'(k), wt[k]});
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    bus.enable    = 1'b1;
    bus.req_valid = 4'b1111;
    bus.out_ready = 1'b0;
    bus.irq_clear = 1'b0;
    for (int k = 0; k < 4; k++) wt[k] = 16'd5;
    @(negedge clk);

    // reset state, no grant while in reset
    chk("rst_out_dir", 32'(bus.out_dir), 0);
    chk("rst_out_weight", 32'(bus.out_weight), 0);
    chk("rst_irq", 32'(bus.stall_irq), 0);
    cyc(4'b0000);

    // round-robin order with immediate drain
    rst = 1'b0;
    bus.out_ready = 1'b1;
    cyc(4'b0001);
    cyc(4'b0010);
    cyc(4'b0100);
    cyc(4'b1000);
    bus.req_valid = 4'b0000;
    cyc(4'b0000);
    cyc(4'b0000);

    // saturating coalesce versus plain push
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b0001;
    wt[0] = 16'hFFF0;
    #1 chk("coal_rdy0", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    wt[0] = 16'h0020;
    #1 chk("coal_rdy1", 32'(bus.req_ready), 32'h1);
    @(negedge clk);
    bus.req_valid = 4'b0000;
    #1;
`ifdef SPIKE_COALESCE_EN
    chk("coal_count", 32'(bus.fifo_count), 1);
    chk("coal_weight", 32'(bus.out_weight), 32'hFFFF);
`else
    chk("coal_count", 32'(bus.fifo_count), 2);
    chk("coal_weight", 32'(bus.out_weight), 32'hFFF0);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wt[0] = 16'd5;
    #1 chk("coal_flush", 32'(bus.fifo_count), 0);
    @(negedge clk);

`ifndef SPIKE_COALESCE_EN
    // fill to full on channel 1, then starve
    bus.req_valid = 4'b0010;
    wt[1] = 16'd3;
    repeat (8) cyc(4'b0010);
    repeat (2) cyc(4'b0000);
    chk("irq_early", 32'(bus.stall_irq), 0);
    repeat (62) cyc(4'b0000);
    chk("irq_at_limit", 32'(bus.stall_irq), 0);
    repeat (2) cyc(4'b0000);
    chk("irq_set", 32'(bus.stall_irq), 1);

    // full with pop requested: no grant, count drops
    bus.out_ready = 1'b1;
    cyc(4'b0000);
    bus.req_valid = 4'b0000;
    cyc(4'b0000);
    cyc(4'b0000);
    chk("irq_sticky", 32'(bus.stall_irq), 1);
    bus.out_ready = 1'b0;
    bus.irq_clear = 1'b1;
    cyc(4'b0000);
    bus.irq_clear = 1'b0;
    chk("irq_cleared", 32'(bus.stall_irq), 0);

    // mid-operation reset with five queued events
    wt[1] = 16'd5;
    rst = 1'b1;
    bus.req_valid = 4'b1111;
    cyc(4'b0000);
    sb.delete();
    rst = 1'b0;
    chk("post_rst_irq", 32'(bus.stall_irq), 0);
    cyc(4'b0001);

    // enable low: no grants, queue still drains
    bus.enable = 1'b0;
    bus.out_ready = 1'b1;
    cyc(4'b0000);
    cyc(4'b0000);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
